// File: rtl/ext_bus_arbiter_if.sv
// ext_bus_arbiter_if: requester A/B handshakes plus the shared ghostbus ext slave port.
interface ext_bus_arbiter_if #(
    parameter int AW = 2,
    parameter int DW = 8
);
    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          ext_we;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ext_addr, ext_wdata, ext_we,
        input  ext_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ext_addr, ext_wdata, ext_we,
        output ext_rdata
    );
endinterface

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: round-robin A/B arbiter serialising accesses onto one ghostbus ext slave.
// Define EXT_ARB_STATS_EN to add saturating grant/conflict counters (a_cnt, b_cnt, conflict_cnt).
module ext_bus_arbiter #(
    parameter int AW     = 2,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    ext_bus_arbiter_if.slave bus
`ifdef EXT_ARB_STATS_EN
    ,
    output logic [15:0] a_cnt,
    output logic [15:0] b_cnt,
    output logic [15:0] conflict_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic          last_b, sel_b, rd, win_b, win_we;
    logic [1:0]    cnt;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // On a tie the requester that was not granted last wins.
    assign win_b     = (bus.a_req && bus.b_req) ? !last_b : bus.b_req;
    assign win_we    = win_b ? bus.b_we : bus.a_we;
    assign win_addr  = win_b ? bus.b_addr : bus.a_addr;
    assign win_wdata = win_b ? bus.b_wdata : bus.a_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_b        <= 1'b1;
            sel_b         <= 1'b0;
            rd            <= 1'b0;
            cnt           <= '0;
            bus.a_gnt     <= 1'b0;
            bus.b_gnt     <= 1'b0;
            bus.a_rvalid  <= 1'b0;
            bus.b_rvalid  <= 1'b0;
            bus.a_rdata   <= '0;
            bus.b_rdata   <= '0;
            bus.ext_addr  <= '0;
            bus.ext_wdata <= '0;
            bus.ext_we    <= 1'b0;
        end else begin
            bus.a_gnt    <= 1'b0;
            bus.b_gnt    <= 1'b0;
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
            bus.ext_we   <= 1'b0;
            case (state)
                IDLE: if (bus.a_req || bus.b_req) begin
                    state         <= ISSUE;
                    sel_b         <= win_b;
                    last_b        <= win_b;
                    rd            <= !win_we;
                    bus.a_gnt     <= !win_b;
                    bus.b_gnt     <= win_b;
                    bus.ext_addr  <= win_addr;
                    bus.ext_wdata <= win_wdata;
                    bus.ext_we    <= win_we;
                end
                ISSUE: begin
                    state <= rd ? WAIT : IDLE;
                    cnt   <= 2'(RD_LAT - 1);
                end
                WAIT: if (cnt == 2'd0) begin
                    state <= IDLE;
                    if (sel_b) begin
                        bus.b_rdata  <= bus.ext_rdata;
                        bus.b_rvalid <= 1'b1;
                    end else begin
                        bus.a_rdata  <= bus.ext_rdata;
                        bus.a_rvalid <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt        <= '0;
            b_cnt        <= '0;
            conflict_cnt <= '0;
        end else begin
            if (bus.a_gnt && a_cnt != 16'hffff) a_cnt <= a_cnt + 16'd1;
            if (bus.b_gnt && b_cnt != 16'hffff) b_cnt <= b_cnt + 16'd1;
            if (state == IDLE && bus.a_req && bus.b_req && conflict_cnt != 16'hffff)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb_ext_bus_arbiter: directed + randomized checks of ext_bus_arbiter against a transaction-level model.
// Define EXT_ARB_STATS_EN to also check the statistics counters.
module tb_ext_bus_arbiter;
    localparam int AW = 2, DW = 8, RD_LAT = 3;
    typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} txn_t;

    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    ext_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
`ifdef EXT_ARB_STATS_EN
    logic [15:0] a_cnt, b_cnt, conflict_cnt;
`endif

    ext_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef EXT_ARB_STATS_EN
        ,
        .a_cnt(a_cnt),
        .b_cnt(b_cnt),
        .conflict_cnt(conflict_cnt)
`endif
    );

    // ext slave: RD_LAT-cycle read pipeline, write on ext_we
    logic [DW-1:0] mem [4];
    logic [DW-1:0] pipe [RD_LAT];
    always @(posedge clk) begin
        if (bus.ext_we) mem[bus.ext_addr] <= bus.ext_wdata;
        pipe[0] <= mem[bus.ext_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.ext_rdata = pipe[RD_LAT-1];

    int checks = 0, failures = 0;
    int cyc = 0, busy = 0, ra = 0, rb = 0, rd_side = -1, rd_due = 0;
    int ga = 0, gb = 0, ties = 0;
    logic last_a = 1'b0;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] model_mem [4];
    txn_t qa[$], qb[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        return {we, a, d};
    endfunction

    task automatic drive();
        bus.a_req = qa.size() != 0;
        if (qa.size() != 0) {bus.a_we, bus.a_addr, bus.a_wdata} = qa[0];
        bus.b_req = qb.size() != 0;
        if (qb.size() != 0) {bus.b_we, bus.b_addr, bus.b_wdata} = qb[0];
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Serve both queues to completion, checking every grant and read return.
    task automatic run();
        int t0, first, exp_c, w;
        logic pa, pb, due;
        txn_t t;
        t0 = cyc;
        if (qa.size() != 0) ra = cyc;
        if (qb.size() != 0) rb = cyc;
        drive();
        while ((qa.size() != 0 || qb.size() != 0 || rd_side >= 0) && cyc - t0 < 400) begin
            tick();
            due = rd_side >= 0 && cyc == rd_due;
            chk("rvalid", {bus.a_rvalid, bus.b_rvalid}, due ? (rd_side == 0 ? 2'b10 : 2'b01) : 2'b00);
            if (due) begin
                chk("rdata", rd_side == 0 ? bus.a_rdata : bus.b_rdata, rd_data);
                rd_side = -1;
            end
            if (bus.a_gnt || bus.b_gnt) begin
                pa = qa.size() != 0 && ra < cyc;
                pb = qb.size() != 0 && rb < cyc;
                if (!pa && !pb) begin
                    chk("spurious_gnt", {bus.a_gnt, bus.b_gnt}, 2'b00);
                    continue;
                end
                w = (pa && pb) ? (last_a ? 1 : 0) : (pb ? 1 : 0);
                first = (pa && pb) ? (ra < rb ? ra : rb) : (pa ? ra : rb);
                exp_c = (first + 1 > busy) ? first + 1 : busy;
                t = w == 1 ? qb[0] : qa[0];
                chk("gnt_who", {bus.a_gnt, bus.b_gnt}, w == 1 ? 2'b01 : 2'b10);
                chk("gnt_cyc", cyc, exp_c);
                chk("ext_we", bus.ext_we, t.we);
                chk("ext_addr", bus.ext_addr, t.addr);
                chk("ext_wdata", bus.ext_wdata, t.wdata);
                if (pa && pb) ties++;
                last_a = w == 0;
                if (w == 1) begin
                    gb++;
                    void'(qb.pop_front());
                    rb = cyc;
                end else begin
                    ga++;
                    void'(qa.pop_front());
                    ra = cyc;
                end
                if (t.we) begin
                    model_mem[t.addr] = t.wdata;
                    busy = cyc + 2;
                end else begin
                    busy = cyc + 2 + RD_LAT;
                    rd_side = w;
                    rd_due = cyc + RD_LAT + 1;
                    rd_data = model_mem[t.addr];
                end
                drive();
            end else begin
                chk("ext_we_idle", bus.ext_we, 1'b0);
            end
        end
        chk("run_done", qa.size() + qb.size() + (rd_side >= 0 ? 1 : 0), 0);
    endtask

    task automatic stats_chk();
        tick();
`ifdef EXT_ARB_STATS_EN
        chk("a_cnt", a_cnt, ga);
        chk("b_cnt", b_cnt, gb);
        chk("conflict_cnt", conflict_cnt, ties);
`endif
    endtask

    task automatic all_zero(string tag);
        chk(tag, {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.ext_we,
                  bus.a_rdata, bus.b_rdata, bus.ext_addr, bus.ext_wdata}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        all_zero("reset_outputs");
        rst_n = 1'b1;
        tick();
        busy = cyc;
        // A write then read back at address 2
        qa.push_back(mk(1'b1, 2'd2, 8'h5a));
        run();
        qa.push_back(mk(1'b0, 2'd2, 8'h00));
        run();
        chk("a_rdata_5a", bus.a_rdata, 8'h5a);
        // B alone: 5 back-to-back writes
        for (int i = 0; i < 5; i++) qb.push_back(mk(1'b1, AW'(i == 2 ? 3 : i % 2), DW'($urandom)));
        run();
        // B write/read of c3
        qb.push_back(mk(1'b1, 2'd3, 8'hc3));
        qb.push_back(mk(1'b0, 2'd3, 8'h00));
        run();
        chk("b_rdata_c3", bus.b_rdata, 8'hc3);
        // both hold reads continuously: alternation
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(1'b0, AW'($urandom), DW'($urandom)));
            qb.push_back(mk(1'b0, AW'($urandom), DW'($urandom)));
        end
        run();
        stats_chk();
        // reset in the middle of an A read
        qa.push_back(mk(1'b0, 2'd1, 8'h00));
        drive();
        for (int i = 0; i < 10 && !bus.a_gnt; i++) tick();
        chk("rst_gnt", bus.a_gnt, 1'b1);
        qa.delete();
        drive();
        tick();
        rst_n = 1'b0;
        #1;
        all_zero("async_reset");
        tick();
        rst_n = 1'b1;
        last_a = 1'b0; ga = 0; gb = 0; ties = 0;
        for (int i = 0; i < 2 * RD_LAT + 4; i++) begin
            tick();
            chk("post_reset_quiet", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid}, 0);
        end
        busy = cyc;
        qa.push_back(mk(1'b1, 2'd0, 8'h11));
        qb.push_back(mk(1'b1, 2'd1, 8'h22));
        run();
        // randomized rounds
        for (int r = 0; r < 30; r++) begin
            int na, nb;
            na = $urandom_range(0, 3);
            nb = $urandom_range(0, 3);
            for (int i = 0; i < na; i++) qa.push_back(mk(1'($urandom), AW'($urandom), DW'($urandom)));
            for (int i = 0; i < nb; i++) qb.push_back(mk(1'($urandom), AW'($urandom), DW'($urandom)));
            run();
        end
        stats_chk();
`ifdef EXT_ARB_STATS_EN
        force dut.a_cnt = 16'hfffe;
        tick();
        release dut.a_cnt;
        for (int i = 0; i < 3; i++) qa.push_back(mk(1'b1, AW'(i), DW'($urandom)));
        run();
        tick();
        chk("a_cnt_sat", a_cnt, 16'hffff);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
